// File: rtl/uart_lora_pkg.sv
// Shared constants and FSM encoding for the LoRa alarm UART transmitter.
package uart_lora_pkg;

    localparam logic [7:0] EVT_SMOKE = 8'h01;
    localparam logic [7:0] EVT_SHAKE = 8'h02;
    localparam logic [7:0] EVT_BELL  = 8'h03;

    localparam int FRAME_BYTES   = 4;
    localparam int BITS_PER_BYTE = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_AUX,
        SEND,
        GAP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a start held high during the last stop-bit cycle chains
// the next byte with no idle bits in between.
module uart_tx_byte
    import uart_lora_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(BITS_PER_BYTE - 1);

    logic             active;
    logic [3:0]       bit_idx;
    logic [CNT_W-1:0] baud_cnt;
    logic [8:0]       shreg;
    logic             last_cycle;
    logic             load;

    assign last_cycle = active && (bit_idx == BIT_LAST) && (baud_cnt == CNT_LAST);
    assign load       = start && (!active || last_cycle);

    // shreg holds the remaining data bits with the stop bit parked on top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            shreg    <= '1;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= last_cycle;
            if (load) begin
                active   <= 1'b1;
                bit_idx  <= '0;
                baud_cnt <= '0;
                shreg    <= {1'b1, data};
                tx       <= 1'b0;
            end else if (active) begin
                if (baud_cnt == CNT_LAST) begin
                    baud_cnt <= '0;
                    if (bit_idx == BIT_LAST) begin
                        active <= 1'b0;
                        tx     <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        tx      <= shreg[0];
                        shreg   <= {1'b1, shreg[8:1]};
                    end
                end else begin
                    baud_cnt <= baud_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_lora_alarm.sv
// Alarm event capture and 4-byte frame sequencing towards the LoRa module,
// paced by AUX and followed by an idle-high gap.
module uart_tx_lora_alarm
    import uart_lora_pkg::*;
#(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 9600,
    parameter logic [7:0] ADDR_H   = 8'h00,
    parameter logic [7:0] ADDR_L   = 8'h02,
    parameter logic [7:0] CHAN     = 8'h17,
    parameter int         GAP_BITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic evt_smoke,
    input  logic evt_shake,
    input  logic evt_bell,
    input  logic lora_aux,
    output logic uart_tx,
    output logic busy,
    output logic frame_done
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int GAP_CYC  = GAP_BITS * BAUD_DIV;
    localparam int GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    // the frame_done cycle already counts as the first idle-high gap cycle
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 2);
    localparam logic [1:0]       IDX_LAST  = 2'(FRAME_BYTES - 1);

    tx_state_t        state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [7:0]       code, code_nxt;
    logic [2:0]       evt_in, evt_q, evt_prev, pend, pend_clr;
    logic             byte_start, byte_done;
    logic [1:0]       byte_sel;
    logic [7:0]       byte_data;

    assign evt_in = {evt_bell, evt_shake, evt_smoke};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q    <= '0;
            evt_prev <= '0;
            pend     <= '0;
        end else begin
            evt_q    <= evt_in;
            evt_prev <= evt_q;
            pend     <= (pend & ~pend_clr) | (evt_q & ~evt_prev);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            code    <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_nxt;
            code    <= code_nxt;
        end
    end

    // while a byte is on the line the serializer already sees the next one
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        gap_nxt    = gap_cnt;
        code_nxt   = code;
        pend_clr   = '0;
        byte_start = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (pend[0]) begin
                    code_nxt  = EVT_SMOKE;
                    pend_clr  = 3'b001;
                    state_nxt = WAIT_AUX;
                end else if (pend[1]) begin
                    code_nxt  = EVT_SHAKE;
                    pend_clr  = 3'b010;
                    state_nxt = WAIT_AUX;
                end else if (pend[2]) begin
                    code_nxt  = EVT_BELL;
                    pend_clr  = 3'b100;
                    state_nxt = WAIT_AUX;
                end
            end
            WAIT_AUX: begin
                if (lora_aux) begin
                    byte_start = 1'b1;
                    idx_nxt    = '0;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                byte_start = (idx != IDX_LAST);
                if (byte_done) begin
                    if (idx == IDX_LAST) begin
                        frame_done = 1'b1;
                        gap_nxt    = '0;
                        state_nxt  = GAP;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = (state == SEND) ? idx + 2'd1 : 2'd0;
        case (byte_sel)
            2'd0:    byte_data = ADDR_H;
            2'd1:    byte_data = ADDR_L;
            2'd2:    byte_data = CHAN;
            default: byte_data = code;
        endcase
    end

    assign busy = (state != IDLE);

    uart_tx_byte #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte (
        .clk  (clk),
        .rst_n(rst_n),
        .start(byte_start),
        .data (byte_data),
        .tx   (uart_tx),
        .done (byte_done)
    );

endmodule
